hazard_control_unit: RTL and testbench
======================================

// Module: hazard_control_unit
// PURPOSE
//  Pipeline sequencer for the 5-stage 24-bit core (fetch/decode/execute/memory/writeback).
//  Detects RAW data hazards between decode and the execute/memory/writeback stages.
//  Detects taken branches resolved in execute (pcWe) and data-memory wait states.
//  Drives stall, flush and operand-forward selects for the stage registers around executionStage.
// PARAMETERS
//  REG_AW          4   register index width (16 architectural registers, all writable, none hardwired)
//  BRANCH_PENALTY  2   cycles fetch/decode are squashed after a taken branch (1..3)
//  MEM_TIMEOUT     15  max consecutive mem_busy cycles before mem_timeout is raised (1..255)
// PORTS
//  clk             in   1      core clock, all state on rising edge
//  reset           in   1      synchronous, active-high
//  dec_rs1         in   REG_AW decode-stage source register A
//  dec_rs2         in   REG_AW decode-stage source register B
//  dec_rs1_used    in   1      decode instruction reads rs1
//  dec_rs2_used    in   1      decode instruction reads rs2
//  ex_regWe        in   1      execute-stage instruction writes a register
//  ex_writeRegFromAlu in 1     1: ALU result, 0: memory load (result late)
//  ex_regToWrite   in   REG_AW execute-stage destination
//  mem_regWe       in   1      memory-stage write enable
//  mem_regToWrite  in   REG_AW memory-stage destination
//  wb_regWe        in   1      writeback-stage write enable
//  wb_regToWrite   in   REG_AW writeback-stage destination
//  ex_pcWe         in   1      taken branch resolved in execute this cycle
//  mem_busy        in   1      data memory not ready; memory stage must hold
//  fetch_stall     out  1      hold PC and fetch/decode register
//  decode_stall    out  1      hold decode/execute register
//  decode_flush    out  1      load bubble into fetch/decode register
//  execute_flush   out  1      load bubble into decode/execute register
//  pipe_hold       out  1      hold execute/memory and memory/writeback registers
//  fwd_sel_a       out  2      op1 source: 00 regfile, 01 execute result, 10 memory, 11 writeback
//  fwd_sel_b       out  2      op2 source, encoding as fwd_sel_a
//  mem_timeout     out  1      sticky error flag
// BEHAVIOUR
//  - States: RUN, BRFLUSH, MEMWAIT (2-bit enum); counter cnt[7:0].
//  - reset=1 at a rising edge: state=RUN, cnt=0, mem_timeout=0; overrides any stall/flush in progress.
//  - While reset is high, outputs force: decode_flush=1, execute_flush=1, all stalls/holds 0, fwd_sel=00.
//  - Hazard match (per used source): src==dest && stage regWe. Decode is combinational; state/cnt/mem_timeout are registered.
//  - Priority per cycle: mem_busy > ex_pcWe > load-use/RAW stall > forward.
//  - MEMWAIT: entered on mem_busy=1 from any state; fetch_stall=decode_stall=pipe_hold=1, no flushes.
//    - cnt increments each busy cycle, saturating at 255; cnt==MEM_TIMEOUT sets mem_timeout (sticky until reset).
//    - mem_busy=0: return to RUN with cnt=0. A branch pending from BRFLUSH resumes with its remaining count.
//  - ex_pcWe=1 in RUN (no mem_busy): decode_flush=1 and execute_flush=1 that cycle; go BRFLUSH, cnt=BRANCH_PENALTY-1.
//  - BRFLUSH: decode_flush=1 each cycle; cnt decrements; cnt==0 -> RUN. A new ex_pcWe restarts cnt.
//    BRANCH_PENALTY=1 returns to RUN directly.
//  - A taken branch always wins over a same-cycle data stall; the squashed instruction needs no stall.
//  - fetch_stall and decode_flush are never both 1 on the same register, except during reset.
// CONFIGURATION
//  FORWARDING_EN defined:
//    - RAW on ex/mem/wb destinations forwards (youngest stage wins: ex > mem > wb), with no stall.
//    - Only load-use (ex match && ex_writeRegFromAlu=0) stalls 1 cycle: fetch_stall=decode_stall=1, execute_flush=1.
//  FORWARDING_EN undefined:
//    - fwd_sel_* is tied to 00.
//    - Any ex/mem match stalls (fetch_stall=decode_stall=1, execute_flush=1) until cleared.
//    - A wb match needs no stall because the regfile writes on the first half-cycle.
// STRUCTURE
//  Package hazard_pkg: state enum hc_state_t, fwd_sel_t encoding constants (FWD_RF/EX/MEM/WB).
//  One sub-module, hazard_match: combinational comparator producing per-source {ex,mem,wb} match vectors.
//  The top module holds the FSM, counter and output muxing.
// TESTING
//  1. Reset held 2 cycles -> both flushes=1; after release: state RUN, all outputs 0, mem_timeout=0.
//  2. [FWD] ex writes r3 (ALU), dec_rs1=3 used -> fwd_sel_a=01, no stall.
//     The same case without FORWARDING_EN -> 2 stall cycles, then issue.
//  3. Load to r5 in ex, dec_rs2=5 -> exactly 1 cycle stall + execute_flush, then fwd_sel_b=10.
//  4. ex_pcWe=1, BRANCH_PENALTY=2 -> execute_flush 1 cycle, decode_flush 2 cycles, then RUN.
//     Concurrent RAW is ignored.
//  5. mem_busy high 16 cycles, MEM_TIMEOUT=15 -> pipe_hold=1 throughout; mem_timeout rises after the 15th cycle.
//     mem_timeout stays set after mem_busy drops, and clears only on reset.
//  6. mem_busy asserted mid-BRFLUSH (cnt=1) -> hold; after release one more decode_flush, then RUN.
//     reset mid-MEMWAIT -> RUN next edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the hazard control unit of the 5-stage
// 24-bit core.
//   hc_state_t : sequencer state (RUN, BRFLUSH, MEMWAIT)
//   fwd_sel_t  : operand source select, FWD_RF/FWD_EX/FWD_MEM/FWD_WB
//   MATCH_*    : bit positions inside the per-source {ex,mem,wb} match vector
//   pickFwd    : youngest-stage-wins forward selection for one source
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BRFLUSH = 2'd1,
    MEMWAIT = 2'd2
  } hc_state_t;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_EX  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;
  localparam fwd_sel_t FWD_WB  = 2'b11;

  localparam int MATCH_EX  = 2;
  localparam int MATCH_MEM = 1;
  localparam int MATCH_WB  = 0;

  // exUsable is low when the execute-stage result is a load that has not
  // returned yet; the execute match is then skipped and the load-use stall
  // covers the gap.
  function automatic fwd_sel_t pickFwd(input logic [2:0] match, input logic exUsable);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (match[MATCH_EX] && exUsable) begin
      sel = FWD_EX;
    end else if (match[MATCH_MEM]) begin
      sel = FWD_MEM;
    end else if (match[MATCH_WB]) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// -----------------------------------------------------------------------------
// hazard_match
// Combinational RAW comparator between the decode-stage sources and the
// execute/memory/writeback destinations. All 16 registers are writable, so
// register 0 is compared like any other.
// Ports:
//   rs1, rs2, rs1Used, rs2Used : decode-stage sources and their use flags
//   exWe/exDest, memWe/memDest, wbWe/wbDest : stage write enables and targets
//   matchA, matchB : per-source {ex,mem,wb} match vectors (see MATCH_*)
// -----------------------------------------------------------------------------
module hazard_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              rs1Used,
  input  logic              rs2Used,
  input  logic              exWe,
  input  logic [REG_AW-1:0] exDest,
  input  logic              memWe,
  input  logic [REG_AW-1:0] memDest,
  input  logic              wbWe,
  input  logic [REG_AW-1:0] wbDest,
  output logic [2:0]        matchA,
  output logic [2:0]        matchB
);

  always_comb begin
    matchA = '0;
    matchB = '0;
    matchA[MATCH_EX]  = rs1Used && exWe  && (rs1 == exDest);
    matchA[MATCH_MEM] = rs1Used && memWe && (rs1 == memDest);
    matchA[MATCH_WB]  = rs1Used && wbWe  && (rs1 == wbDest);
    matchB[MATCH_EX]  = rs2Used && exWe  && (rs2 == exDest);
    matchB[MATCH_MEM] = rs2Used && memWe && (rs2 == memDest);
    matchB[MATCH_WB]  = rs2Used && wbWe  && (rs2 == wbDest);
  end

endmodule

// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
// Pipeline sequencer for the 5-stage 24-bit core. Produces stall, flush and
// operand-forward selects for the registers around the execute stage.
// Priority each cycle: mem_busy > ex_pcWe > data stall > forward.
// Build option: define FORWARDING_EN to forward ex/mem/wb results (only a
// load-use stalls); without it fwd_sel_* stay 00 and any ex/mem RAW stalls.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   dec_*                 : decode-stage sources and use flags
//   ex_/mem_/wb_*         : stage write enables and destinations
//   ex_writeRegFromAlu    : 1 ALU result, 0 load (data arrives a stage late)
//   ex_pcWe               : taken branch resolved in execute
//   mem_busy              : data memory wait state
//   fetch_stall, decode_stall, decode_flush, execute_flush, pipe_hold
//   fwd_sel_a, fwd_sel_b  : operand sources (FWD_RF/EX/MEM/WB)
//   mem_timeout           : sticky flag, memory busy for MEM_TIMEOUT cycles
//   dbgState              : current sequencer state
// -----------------------------------------------------------------------------
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW         = 4,
  parameter int BRANCH_PENALTY = 2,
  parameter int MEM_TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic              dec_rs1_used,
  input  logic              dec_rs2_used,
  input  logic              ex_regWe,
  input  logic              ex_writeRegFromAlu,
  input  logic [REG_AW-1:0] ex_regToWrite,
  input  logic              mem_regWe,
  input  logic [REG_AW-1:0] mem_regToWrite,
  input  logic              wb_regWe,
  input  logic [REG_AW-1:0] wb_regToWrite,
  input  logic              ex_pcWe,
  input  logic              mem_busy,
  output logic              fetch_stall,
  output logic              decode_stall,
  output logic              decode_flush,
  output logic              execute_flush,
  output logic              pipe_hold,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic              mem_timeout,
  output hc_state_t         dbgState
);

  localparam logic [7:0] BR_RELOAD = 8'(BRANCH_PENALTY - 1);
  localparam logic [7:0] MEM_LIMIT = 8'(MEM_TIMEOUT);

  hc_state_t  state, stateNext, effState;
  logic [7:0] cnt, cntNext, effCnt, busyBase, busyCnt;
  logic [7:0] brCnt, brCntNext;
  logic       brPending, brPendingNext;
  logic       memTimeoutNext;
  logic [2:0] matchA, matchB;
  logic       dataStall;
  fwd_sel_t   fwdA, fwdB;

  hazard_match #(.REG_AW(REG_AW)) u_match (
    .rs1     (dec_rs1),
    .rs2     (dec_rs2),
    .rs1Used (dec_rs1_used),
    .rs2Used (dec_rs2_used),
    .exWe    (ex_regWe),
    .exDest  (ex_regToWrite),
    .memWe   (mem_regWe),
    .memDest (mem_regToWrite),
    .wbWe    (wb_regWe),
    .wbDest  (wb_regToWrite),
    .matchA  (matchA),
    .matchB  (matchB)
  );

`ifdef FORWARDING_EN
  always_comb begin
    fwdA      = pickFwd(matchA, ex_writeRegFromAlu);
    fwdB      = pickFwd(matchB, ex_writeRegFromAlu);
    dataStall = (matchA[MATCH_EX] || matchB[MATCH_EX]) && !ex_writeRegFromAlu;
  end
`else
  // The regfile writes in the first half-cycle, so a wb match never stalls.
  logic unusedFwdInputs;
  always_comb begin
    fwdA            = FWD_RF;
    fwdB            = FWD_RF;
    dataStall       = matchA[MATCH_EX] || matchA[MATCH_MEM] ||
                      matchB[MATCH_EX] || matchB[MATCH_MEM];
    unusedFwdInputs = ^{ex_writeRegFromAlu, matchA[MATCH_WB], matchB[MATCH_WB]};
  end
`endif

  // Once memory is ready, MEMWAIT behaves as the state it interrupted, so a
  // branch squash suspended by a wait resumes in the release cycle itself.
  always_comb begin
    effState = state;
    effCnt   = cnt;
    if (state == MEMWAIT) begin
      effState = brPending ? BRFLUSH : RUN;
      effCnt   = brCnt;
    end
    busyBase = (state == MEMWAIT) ? cnt : 8'd0;
    busyCnt  = (busyBase == 8'hFF) ? 8'hFF : busyBase + 8'd1;
  end

  always_comb begin
    stateNext      = state;
    cntNext        = cnt;
    brCntNext      = brCnt;
    brPendingNext  = brPending;
    memTimeoutNext = mem_timeout;
    fetch_stall    = 1'b0;
    decode_stall   = 1'b0;
    decode_flush   = 1'b0;
    execute_flush  = 1'b0;
    pipe_hold      = 1'b0;
    fwd_sel_a      = fwdA;
    fwd_sel_b      = fwdB;

    if (mem_busy) begin
      fetch_stall  = 1'b1;
      decode_stall = 1'b1;
      pipe_hold    = 1'b1;
      stateNext    = MEMWAIT;
      cntNext      = busyCnt;
      if (state == BRFLUSH) begin
        brPendingNext = 1'b1;
        brCntNext     = cnt;
      end else if (state == RUN) begin
        brPendingNext = 1'b0;
        brCntNext     = 8'd0;
      end
      if (busyCnt == MEM_LIMIT) begin
        memTimeoutNext = 1'b1;
      end
    end else begin
      brPendingNext = 1'b0;
      brCntNext     = 8'd0;
      if (ex_pcWe) begin
        // A taken branch squashes decode, so any data stall there is moot.
        decode_flush  = 1'b1;
        execute_flush = 1'b1;
        cntNext       = BR_RELOAD;
        stateNext     = (BR_RELOAD == 8'd0) ? RUN : BRFLUSH;
      end else if (effState == BRFLUSH) begin
        decode_flush = 1'b1;
        if (effCnt <= 8'd1) begin
          stateNext = RUN;
          cntNext   = 8'd0;
        end else begin
          stateNext = BRFLUSH;
          cntNext   = effCnt - 8'd1;
        end
      end else begin
        stateNext = RUN;
        cntNext   = 8'd0;
        if (dataStall) begin
          fetch_stall   = 1'b1;
          decode_stall  = 1'b1;
          execute_flush = 1'b1;
        end
      end
    end

    if (reset) begin
      fetch_stall   = 1'b0;
      decode_stall  = 1'b0;
      pipe_hold     = 1'b0;
      decode_flush  = 1'b1;
      execute_flush = 1'b1;
      fwd_sel_a     = FWD_RF;
      fwd_sel_b     = FWD_RF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      cnt         <= 8'd0;
      brCnt       <= 8'd0;
      brPending   <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= stateNext;
      cnt         <= cntNext;
      brCnt       <= brCntNext;
      brPending   <= brPendingNext;
      mem_timeout <= memTimeoutNext;
    end
  end

  assign dbgState = state;

endmodule

// File: tb/tb_hazard_control_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_control_unit
// Directed bench for hazard_control_unit with default parameters
// (BRANCH_PENALTY=2, MEM_TIMEOUT=15). Expected output vectors are written by
// hand; forwarding-dependent values follow the FORWARDING_EN build option.
// Output vector layout: {fetch_stall, decode_stall, decode_flush,
// execute_flush, pipe_hold, fwd_sel_a, fwd_sel_b, mem_timeout}.
// -----------------------------------------------------------------------------
module tb_hazard_control_unit;
  import hazard_pkg::*;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0] dec_rs1, dec_rs2, ex_regToWrite, mem_regToWrite, wb_regToWrite;
  logic       dec_rs1_used, dec_rs2_used, ex_regWe, ex_writeRegFromAlu;
  logic       mem_regWe, wb_regWe, ex_pcWe, mem_busy;
  logic       fetch_stall, decode_stall, decode_flush, execute_flush, pipe_hold;
  logic [1:0] fwd_sel_a, fwd_sel_b;
  logic       mem_timeout;
  hc_state_t  dbgState;

  hazard_control_unit dut (
    .clk                (clk),
    .reset              (reset),
    .dec_rs1            (dec_rs1),
    .dec_rs2            (dec_rs2),
    .dec_rs1_used       (dec_rs1_used),
    .dec_rs2_used       (dec_rs2_used),
    .ex_regWe           (ex_regWe),
    .ex_writeRegFromAlu (ex_writeRegFromAlu),
    .ex_regToWrite      (ex_regToWrite),
    .mem_regWe          (mem_regWe),
    .mem_regToWrite     (mem_regToWrite),
    .wb_regWe           (wb_regWe),
    .wb_regToWrite      (wb_regToWrite),
    .ex_pcWe            (ex_pcWe),
    .mem_busy           (mem_busy),
    .fetch_stall        (fetch_stall),
    .decode_stall       (decode_stall),
    .decode_flush       (decode_flush),
    .execute_flush      (execute_flush),
    .pipe_hold          (pipe_hold),
    .fwd_sel_a          (fwd_sel_a),
    .fwd_sel_b          (fwd_sel_b),
    .mem_timeout        (mem_timeout),
    .dbgState           (dbgState)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];
  logic [9:0] obsVec;
  assign obsVec = {fetch_stall, decode_stall, decode_flush, execute_flush,
                   pipe_hold, fwd_sel_a, fwd_sel_b, mem_timeout};

  function automatic logic [9:0] ov(input logic fs, input logic ds, input logic df,
                                    input logic ef, input logic ph, input logic [1:0] fa,
                                    input logic [1:0] fb, input logic mt);
    return {fs, ds, df, ef, ph, fa, fb, mt};
  endfunction

  task automatic chkOut(input string tag, input logic [9:0] expv);
    logic [9:0] e;
    exp_q.push_back(expv);
    e = exp_q.pop_front();
    checks++;
    assert (obsVec === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obsVec, e);
    end
  endtask

  task automatic chkState(input string tag, input hc_state_t expS);
    checks++;
    assert (dbgState === expS) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, dbgState, expS);
    end
  endtask

  // driver tasks
  task automatic idle();
    dec_rs1 = '0; dec_rs2 = '0; dec_rs1_used = 1'b0; dec_rs2_used = 1'b0;
    ex_regWe = 1'b0; ex_writeRegFromAlu = 1'b1; ex_regToWrite = '0;
    mem_regWe = 1'b0; mem_regToWrite = '0; wb_regWe = 1'b0; wb_regToWrite = '0;
    ex_pcWe = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic exWrite(input logic [3:0] r, input logic fromAlu);
    ex_regWe = 1'b1; ex_regToWrite = r; ex_writeRegFromAlu = fromAlu;
  endtask

  // Advance a producer one stage: ex -> mem -> wb.
  task automatic advance();
    wb_regWe = mem_regWe; wb_regToWrite = mem_regToWrite;
    mem_regWe = ex_regWe; mem_regToWrite = ex_regToWrite;
    ex_regWe = 1'b0; ex_regToWrite = '0; ex_writeRegFromAlu = 1'b1;
  endtask

  localparam logic [9:0] NONE = 10'b0;

  initial begin
    // 1. reset
    idle();
    reset = 1'b1;
    tick();
    settle();
    chkOut("reset_c1", ov(0, 0, 1, 1, 0, 2'b00, 2'b00, 0));
    mem_busy = 1'b1; ex_pcWe = 1'b1;
    settle();
    chkOut("reset_forced", ov(0, 0, 1, 1, 0, 2'b00, 2'b00, 0));
    tick();
    reset = 1'b0;
    idle();
    settle();
    chkOut("after_reset", NONE);
    chkState("after_reset_state", RUN);

    // 2. ALU RAW on r3 via rs1
    dec_rs1 = 4'd3; dec_rs1_used = 1'b1; exWrite(4'd3, 1'b1);
    settle();
    chkOut("raw_ex", FWD ? ov(0, 0, 0, 0, 0, 2'b01, 2'b00, 0) : ov(1, 1, 0, 1, 0, 2'b00, 2'b00, 0));
    tick(); advance(); settle();
    chkOut("raw_mem", FWD ? ov(0, 0, 0, 0, 0, 2'b10, 2'b00, 0) : ov(1, 1, 0, 1, 0, 2'b00, 2'b00, 0));
    tick(); advance(); settle();
    chkOut("raw_wb", FWD ? ov(0, 0, 0, 0, 0, 2'b11, 2'b00, 0) : NONE);
    tick(); idle();
    dec_rs1 = 4'd3; dec_rs1_used = 1'b0; exWrite(4'd3, 1'b1);
    settle();
    chkOut("unused_src", NONE);
    ex_regWe = 1'b0; dec_rs1_used = 1'b1;
    settle();
    chkOut("no_we", NONE);
    idle();
    dec_rs2 = 4'd0; dec_rs2_used = 1'b1; wb_regWe = 1'b1; wb_regToWrite = 4'd0;
    settle();
    chkOut("r0_wb", FWD ? ov(0, 0, 0, 0, 0, 2'b00, 2'b11, 0) : NONE);
    idle();
    dec_rs1 = 4'd7; dec_rs1_used = 1'b1; exWrite(4'd7, 1'b1);
    mem_regWe = 1'b1; mem_regToWrite = 4'd7;
    settle();
    chkOut("ex_over_mem", FWD ? ov(0, 0, 0, 0, 0, 2'b01, 2'b00, 0) : ov(1, 1, 0, 1, 0, 2'b00, 2'b00, 0));
    tick(); idle();

    // 3. load-use on r5 via rs2
    dec_rs2 = 4'd5; dec_rs2_used = 1'b1; exWrite(4'd5, 1'b0);
    settle();
    chkOut("load_use", ov(1, 1, 0, 1, 0, 2'b00, 2'b00, 0));
    tick(); advance(); settle();
    chkOut("load_mem", FWD ? ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 0) : ov(1, 1, 0, 1, 0, 2'b00, 2'b00, 0));
    tick(); advance(); settle();
    chkOut("load_wb", FWD ? ov(0, 0, 0, 0, 0, 2'b00, 2'b11, 0) : NONE);
    tick(); idle();

    // 4. taken branch with concurrent RAW
    ex_pcWe = 1'b1; dec_rs1 = 4'd3; dec_rs1_used = 1'b1; exWrite(4'd3, 1'b1);
    settle();
    chkOut("br_first", ov(0, 0, 1, 1, 0, FWD ? 2'b01 : 2'b00, 2'b00, 0));
    tick();
    chkState("br_state", BRFLUSH);
    ex_pcWe = 1'b0;
    settle();
    chkOut("br_second", ov(0, 0, 1, 0, 0, FWD ? 2'b01 : 2'b00, 2'b00, 0));
    tick(); idle(); settle();
    chkState("br_done_state", RUN);
    chkOut("br_done", NONE);
    ex_pcWe = 1'b1;
    tick();
    settle();
    chkOut("br_restart", ov(0, 0, 1, 1, 0, 2'b00, 2'b00, 0));
    tick();
    chkState("br_restart_state", BRFLUSH);
    ex_pcWe = 1'b0;
    settle();
    chkOut("br_restart_tail", ov(0, 0, 1, 0, 0, 2'b00, 2'b00, 0));
    tick();
    chkState("br_restart_done", RUN);

    // 5. memory timeout
    for (int i = 1; i <= 16; i++) begin
      mem_busy = 1'b1;
      settle();
      chkOut($sformatf("busy_c%0d", i), ov(1, 1, 0, 0, 1, 2'b00, 2'b00, (i >= 16) ? 1'b1 : 1'b0));
      tick();
    end
    chkState("busy_state", MEMWAIT);
    mem_busy = 1'b0;
    settle();
    chkOut("busy_release", ov(0, 0, 0, 0, 0, 2'b00, 2'b00, 1));
    tick();
    chkState("busy_release_state", RUN);
    chkOut("timeout_sticky", ov(0, 0, 0, 0, 0, 2'b00, 2'b00, 1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chkOut("timeout_cleared", NONE);

    // 6. memory wait interrupting a branch squash
    ex_pcWe = 1'b1;
    tick();
    ex_pcWe = 1'b0; mem_busy = 1'b1;
    settle();
    chkOut("brmem_hold", ov(1, 1, 0, 0, 1, 2'b00, 2'b00, 0));
    tick(); tick(); tick();
    chkState("brmem_state", MEMWAIT);
    chkOut("brmem_hold_late", ov(1, 1, 0, 0, 1, 2'b00, 2'b00, 0));
    mem_busy = 1'b0;
    settle();
    chkOut("brmem_resume", ov(0, 0, 1, 0, 0, 2'b00, 2'b00, 0));
    tick();
    chkState("brmem_done_state", RUN);
    chkOut("brmem_done", NONE);

    // reset during a memory wait
    mem_busy = 1'b1;
    tick();
    chkState("wait_before_reset", MEMWAIT);
    reset = 1'b1;
    settle();
    chkOut("wait_reset_forced", ov(0, 0, 1, 1, 0, 2'b00, 2'b00, 0));
    tick();
    chkState("wait_reset_state", RUN);
    reset = 1'b0; mem_busy = 1'b0;
    settle();
    chkOut("wait_reset_out", NONE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
